// File: rtl/debounce_edge.sv
// Multi-channel input conditioner: two-flop synchronizer, per-channel stability
// filter gated by a sample-tick enable, and registered level plus rise/fall strobes.
module debounce_edge #(
   parameter int N      = 1,
   parameter int STABLE = 1000,
   parameter int CNT_W  = 16
) (
   input  logic         clk,
   input  logic         res,
   input  logic         en,
   input  logic [N-1:0] din,
   output logic [N-1:0] q,
   output logic [N-1:0] rise,
   output logic [N-1:0] fall
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE - 1);

   logic [N-1:0]     s0;
   logic [N-1:0]     s1;
   logic [CNT_W-1:0] cnt [N];

   // Synchronizer runs every edge; the filter and strobes advance per channel.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         s0   <= {N{1'b0}};
         s1   <= {N{1'b0}};
         q    <= {N{1'b0}};
         rise <= {N{1'b0}};
         fall <= {N{1'b0}};
         for (int i = 0; i < N; i++) begin
            cnt[i] <= CNT_ZERO;
         end
      end else begin
         s0 <= din;
         s1 <= s0;
         for (int i = 0; i < N; i++) begin
            rise[i] <= 1'b0;
            fall[i] <= 1'b0;
            if (s1[i] == q[i]) begin
               // any agreeing sample aborts a pending change
               cnt[i] <= CNT_ZERO;
            end else if (!en) begin
               cnt[i] <= cnt[i];
            end else if (cnt[i] == CNT_LAST) begin
               q[i]    <= s1[i];
               cnt[i]  <= CNT_ZERO;
               rise[i] <= s1[i];
               fall[i] <= ~s1[i];
            end else begin
               cnt[i] <= cnt[i] + CNT_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_debounce_edge.sv
// Randomized and directed bench for debounce_edge; one instance with STABLE=4
// and one with STABLE=1, both checked every cycle against a run-length model.
module tb_debounce_edge;

   logic       clk = 1'b0;
   logic       res = 1'b0;
   logic       en = 1'b1;
   logic [1:0] din_a = 2'b00;
   logic [1:0] din_b = 2'b00;
   logic [1:0] q_a, rise_a, fall_a;
   logic [1:0] q_b, rise_b, fall_b;

   int n_tests = 0;
   int n_fail  = 0;

   debounce_edge #(.N(2), .STABLE(4), .CNT_W(16)) u_dut_a (
      .clk(clk), .res(res), .en(en), .din(din_a),
      .q(q_a), .rise(rise_a), .fall(fall_a)
   );

   debounce_edge #(.N(2), .STABLE(1), .CNT_W(4)) u_dut_b (
      .clk(clk), .res(res), .en(en), .din(din_b),
      .q(q_b), .rise(rise_b), .fall(fall_b)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // Reference: a channel commits once it has seen STABLE enabled edges in one
   // unbroken run of synchronized samples disagreeing with the current level.
   bit [3:0] hist0 = 4'h0, hist1 = 4'h0;
   bit [3:0] m_q = 4'h0, m_rise = 4'h0, m_fall = 4'h0;
   int       run_len [4] = '{0, 0, 0, 0};

   always @(posedge clk or posedge res) begin
      if (res) begin
         hist0 = 4'h0; hist1 = 4'h0;
         m_q = 4'h0; m_rise = 4'h0; m_fall = 4'h0;
         for (int c = 0; c < 4; c++) run_len[c] = 0;
      end else begin
         for (int c = 0; c < 4; c++) begin
            int stable_len;
            stable_len = (c < 2) ? 4 : 1;
            m_rise[c] = 1'b0;
            m_fall[c] = 1'b0;
            if (hist1[c] == m_q[c]) run_len[c] = 0;
            else if (en) begin
               run_len[c] = run_len[c] + 1;
               if (run_len[c] == stable_len) begin
                  m_q[c] = hist1[c];
                  if (hist1[c]) m_rise[c] = 1'b1;
                  else m_fall[c] = 1'b1;
                  run_len[c] = 0;
               end
            end
         end
         hist1 = hist0;
         hist0 = {din_b, din_a};
      end
   end

   always @(negedge clk) begin
      check_eq("q",    {28'd0, q_b, q_a},       {28'd0, m_q});
      check_eq("rise", {28'd0, rise_b, rise_a}, {28'd0, m_rise});
      check_eq("fall", {28'd0, fall_b, fall_a}, {28'd0, m_fall});
      check_eq("excl", {28'd0, rise_b & fall_b, rise_a & fall_a}, 32'd0);
   end

   task automatic cycles(input int n);
      for (int k = 0; k < n; k++) @(posedge clk);
      #1;
   endtask

   // Inputs were just set between edges; the next edge is edge 0.
   task automatic expect_rise_a0(input string tag, input int exp_edge);
      int found;
      found = -1;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk);
         #1;
         if (found < 0 && rise_a[0] === 1'b1) found = k;
      end
      check_eq(tag, 32'(found), 32'(exp_edge));
   endtask

   initial begin
      #1 res = 1'b1;
      cycles(3);
      res = 1'b0;
      cycles(20);

      // clean rise on channel 0, channel 1 idle
      din_a[0] = 1'b1;
      expect_rise_a0("lat_clean", 5);

      // bounce: 1 for 3 cycles, 0 for 1, then 1 held
      din_a[0] = 1'b0;
      cycles(12);
      din_a[0] = 1'b1;
      cycles(3);
      din_a[0] = 1'b0;
      cycles(1);
      din_a[0] = 1'b1;
      expect_rise_a0("lat_bounce", 5);

      // enable gating: tick every third cycle, falling channel 1
      din_a[1] = 1'b1;
      cycles(10);
      din_a[1] = 1'b0;
      for (int k = 0; k < 40; k++) begin
         en = (k % 3 == 0);
         cycles(1);
      end
      en = 1'b1;

      // reset during a pending rise, with other outputs high
      din_b = 2'b11;
      din_a[0] = 1'b0;
      cycles(12);
      din_a[0] = 1'b1;
      cycles(3);
      res = 1'b1;
      #1;
      check_eq("rst_q",    {28'd0, q_b, q_a}, 32'd0);
      check_eq("rst_edge", {24'd0, rise_b, rise_a, fall_b, fall_a}, 32'd0);
      cycles(1);
      res = 1'b0;
      expect_rise_a0("lat_after_rst", 5);

      // STABLE=1 channel toggling every 4 cycles
      for (int t = 0; t < 10; t++) begin
         int found;
         found = -1;
         din_b[0] = ~din_b[0];
         for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (found < 0 && q_b[0] === din_b[0]) found = k;
         end
         check_eq("lat_s1", 32'(found), 32'd2);
      end

      // randomized phase
      for (int k = 0; k < 3000; k++) begin
         for (int b = 0; b < 2; b++) begin
            if ($urandom_range(0, 7) == 0) din_a[b] = ~din_a[b];
            if ($urandom_range(0, 3) == 0) din_b[b] = ~din_b[b];
         end
         en = ($urandom_range(0, 3) != 0);
         cycles(1);
      end

      @(posedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
